// File: rtl/uc_pkg.sv
// Shared types and helpers for the unit-clause path.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   UC_LENGTH, UCQ_SIZE : number of variables, depth of each unit clause queue
//   LIT_W, VAR_W        : literal width (negation flag + variable index), index width
//   lit_t, var_t        : literal and variable-index types
//   lit_var(), lit_neg(): literal field extraction
package uc_pkg;

  localparam int UC_LENGTH = 1024;
  localparam int UCQ_SIZE  = 16;
  localparam int LIT_W     = $clog2(UC_LENGTH) + 1;
  localparam int VAR_W     = LIT_W - 1;

  typedef logic [LIT_W-1:0] lit_t;
  typedef logic [VAR_W-1:0] var_t;

  // Variable index: every bit below the negation flag.
  function automatic var_t lit_var(lit_t lit);
    return lit[VAR_W-1:0];
  endfunction

  // Negation flag: MSB of the literal.
  function automatic logic lit_neg(lit_t lit);
    return lit[LIT_W-1];
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational; the caller owns the pointer register.
// Backpressure: ptr_nxt only moves past the grant when adv is high.
//
// Ports:
//   req     in  N      request vector
//   ptr     in  IDX_W  current round-robin start position
//   adv     in  1      granted request was consumed this cycle
//   gnt     out N      one-hot grant (all zero when no request)
//   gnt_idx out IDX_W  index of the granted request
//   gnt_vld out 1      some request is granted
//   ptr_nxt out IDX_W  pointer value for the next cycle
module rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] ptr_nxt
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Scan N positions starting at ptr; the first hit wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (adv && gnt_vld) begin
      ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: dedups engine literals against the assignment table and broadcasts new ones to every UCQ.
// Latency: literal accepted at edge k is pushed during cycle k+1; its slot is ready again in cycle k+2.
// Backpressure: any ucq_full stalls the winning new literal in place; one-deep slots hold src_ready low meanwhile.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous restart: wipes table, conflict, pending slots and pointer
//   src_valid  per-source offer; transfer on src_valid & src_ready
//   src_lit    per-source literal (MSB = negated, low bits = variable)
//   src_ready  per-source slot empty (low while clear is asserted)
//   ucq_full   full flags from the unit clause queues
//   ucq_push   broadcast push strobe, all bits identical
//   uca2ucq    literal being pushed, zero when idle
//   conflict   sticky: a literal contradicted an existing assignment
module uc_arbiter
  import uc_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int NUM_UCQ   = 4,
  parameter int UC_LENGTH = uc_pkg::UC_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  lit_t [NUM_SRC-1:0]   src_lit,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic [NUM_UCQ-1:0]   ucq_full,
  output logic [NUM_UCQ-1:0]   ucq_push,
  output lit_t                 uca2ucq,
  output logic                 conflict
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Pending slots, one per source.
  logic [NUM_SRC-1:0] pend_v_q, pend_v_d;
  lit_t [NUM_SRC-1:0] pend_lit_q, pend_lit_d;

  // Assignment table: assigned flag plus the polarity that was assigned.
  logic [UC_LENGTH-1:0] tbl_asg_q, tbl_asg_d;
  logic [UC_LENGTH-1:0] tbl_neg_q, tbl_neg_d;

  logic             conflict_q, conflict_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  // Selection and decode.
  logic [NUM_SRC-1:0] sel_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;
  logic [IDX_W-1:0]   rr_nxt;
  lit_t               sel_lit;
  var_t               sel_var;
  logic               sel_neg;
  logic               ent_asg;
  logic               ent_neg;
  logic               any_full;
  logic               consume;
  logic               push;
  logic [NUM_SRC-1:0] accept;

  rr_arb #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req     (pend_v_q),
    .ptr     (rr_q),
    .adv     (consume),
    .gnt     (sel_gnt),
    .gnt_idx (sel_idx),
    .gnt_vld (sel_vld),
    .ptr_nxt (rr_nxt)
  );

  assign sel_lit  = pend_lit_q[sel_idx];
  assign sel_var  = lit_var(sel_lit);
  assign sel_neg  = lit_neg(sel_lit);
  assign ent_asg  = tbl_asg_q[sel_var];
  assign ent_neg  = tbl_neg_q[sel_var];
  assign any_full = |ucq_full;

  // A slot only accepts when empty, so accept never overlaps a consume.
  assign src_ready = ~pend_v_q & {NUM_SRC{~clear}};
  assign accept    = src_valid & src_ready;

  assign ucq_push = {NUM_UCQ{push}};
  assign uca2ucq  = push ? sel_lit : '0;
  assign conflict = conflict_q;

  // Outcome of the picked entry: drop, conflict-drop, push, or stall.
  always_comb begin
    consume    = 1'b0;
    push       = 1'b0;
    conflict_d = conflict_q;
    tbl_asg_d  = tbl_asg_q;
    tbl_neg_d  = tbl_neg_q;
    if (clear) begin
      conflict_d = 1'b0;
      tbl_asg_d  = '0;
      tbl_neg_d  = '0;
    end else if (sel_vld) begin
      if (conflict_q) begin
        // Once in conflict the solve is dead; drain without touching the table.
        consume = 1'b1;
      end else if (ent_asg) begin
        consume = 1'b1;
        if (ent_neg != sel_neg) begin
          conflict_d = 1'b1;
        end
      end else if (!any_full) begin
        consume            = 1'b1;
        push               = 1'b1;
        tbl_asg_d[sel_var] = 1'b1;
        tbl_neg_d[sel_var] = sel_neg;
      end
      // else: stall, winner stays pending and rr holds.
    end
  end

  // Slot and pointer next state.
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_lit_d = pend_lit_q;
    rr_d       = rr_nxt;
    if (clear) begin
      pend_v_d = '0;
      rr_d     = '0;
    end else begin
      if (consume) begin
        pend_v_d = pend_v_d & ~sel_gnt;
      end
      pend_v_d = pend_v_d | accept;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          pend_lit_d[i] = src_lit[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q   <= '0;
      pend_lit_q <= '0;
      tbl_asg_q  <= '0;
      tbl_neg_q  <= '0;
      conflict_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_lit_q <= pend_lit_d;
      tbl_asg_q  <= tbl_asg_d;
      tbl_neg_q  <= tbl_neg_d;
      conflict_q <= conflict_d;
      rr_q       <= rr_d;
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
module tb_uc_arbiter;
  import uc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic [3:0]   src_valid;
  lit_t [3:0]   src_lit;
  logic [3:0]   src_ready;
  logic [3:0]   ucq_full;
  logic [3:0]   ucq_push;
  lit_t         uca2ucq;
  logic         conflict;

  int   n_tests = 0;
  int   n_fail  = 0;
  lit_t sb[$];
  lit_t mon_exp;

  always #5 clk = ~clk;

  uc_arbiter #(
    .NUM_SRC   (4),
    .NUM_UCQ   (4),
    .UC_LENGTH (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .src_valid (src_valid),
    .src_lit   (src_lit),
    .src_ready (src_ready),
    .ucq_full  (ucq_full),
    .ucq_push  (ucq_push),
    .uca2ucq   (uca2ucq),
    .conflict  (conflict)
  );

  // Scoreboard monitor: every push must match the next expected literal.
  always @(negedge clk) begin
    if (!rst && ucq_push !== 4'b0000) begin
      n_tests++;
      if (ucq_push !== 4'b1111) begin
        n_fail++;
        $display("FAIL push_broadcast: ucq_push=%b required 1111", ucq_push);
      end
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: uca2ucq=%h required no push", uca2ucq);
      end else begin
        mon_exp = sb.pop_front();
        if (uca2ucq !== mon_exp) begin
          n_fail++;
          $display("FAIL push_lit: uca2ucq=%h required %h", uca2ucq, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input lit_t l);
    src_lit[i]   = l;
    src_valid    = '0;
    src_valid[i] = 1'b1;
    step();
    src_valid = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; src_valid = '0; src_lit = '0; ucq_full = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (src_ready !== 4'b1111) begin n_fail++; $display("FAIL reset_ready: got %b required 1111", src_ready); end
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL reset_push: got %b required 0000", ucq_push); end
    n_tests++; if (uca2ucq !== 11'h000) begin n_fail++; $display("FAIL reset_lit: got %h required 000", uca2ucq); end
    n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b required 0", conflict); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_push();
    sb.push_back(11'h005);
    offer(0, 11'h005);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h005) begin n_fail++; $display("FAIL single_push_k1: push=%b lit=%h required 1111 005", ucq_push, uca2ucq); end
    n_tests++; if (src_ready[0] !== 1'b0) begin n_fail++; $display("FAIL single_ready_k1: got %b required 0", src_ready[0]); end
    step();
    @(negedge clk);
    n_tests++; if (src_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready_k2: got %b required 1", src_ready[0]); end
    n_tests++; if (ucq_push !== 4'b0000 || uca2ucq !== 11'h000) begin n_fail++; $display("FAIL single_idle_k2: push=%b lit=%h required 0000 000", ucq_push, uca2ucq); end
    step();
  endtask

  task automatic test_fairness();
    lit_t base;
    lit_t want;
    pulse_clear();
    for (int b = 0; b < 2; b++) begin
      base = (b == 0) ? 11'h000 : 11'h020;
      for (int i = 0; i < 4; i++) begin
        src_lit[i] = base + lit_t'(i + 1);
        sb.push_back(base + lit_t'(i + 1));
      end
      src_valid = 4'b1111;
      step();
      src_valid = '0;
      for (int c = 0; c < 4; c++) begin
        want = base + lit_t'(c + 1);
        @(negedge clk);
        n_tests++;
        if (ucq_push !== 4'b1111 || uca2ucq !== want) begin
          n_fail++;
          $display("FAIL fair_order: burst %0d slot %0d push=%b lit=%h required 1111 %h", b, c, ucq_push, uca2ucq, want);
        end
        step();
      end
      @(negedge clk);
      n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL fair_idle: push=%b required 0000", ucq_push); end
      step();
    end
  endtask

  task automatic test_dup_conflict();
    sb.push_back(11'h007);
    offer(0, 11'h007);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h007) begin n_fail++; $display("FAIL dup_first_push: push=%b lit=%h required 1111 007", ucq_push, uca2ucq); end
    step();
    offer(1, 11'h007);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL dup_no_push: push=%b required 0000", ucq_push); end
    step();
    @(negedge clk);
    n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL dup_no_conflict: got %b required 0", conflict); end
    step();
    offer(2, 11'h407);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL conf_no_push: push=%b required 0000", ucq_push); end
    n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conf_k1: got %b required 0", conflict); end
    step();
    @(negedge clk);
    n_tests++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_k2: got %b required 1", conflict); end
    step();
    offer(3, 11'h008);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL conf_drain_no_push: push=%b required 0000", ucq_push); end
    step();
    @(negedge clk);
    n_tests++; if (src_ready[3] !== 1'b1 || conflict !== 1'b1) begin n_fail++; $display("FAIL conf_drain: ready3=%b conflict=%b required 1 1", src_ready[3], conflict); end
    step();
  endtask

  task automatic test_backpressure();
    pulse_clear();
    ucq_full = 4'b0100;
    offer(0, 11'h010);
    offer(1, 11'h011);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (ucq_push !== 4'b0000 || src_ready[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d push=%b ready=%b required 0000 xx00", c, ucq_push, src_ready);
      end
      step();
    end
    ucq_full = 4'b0000;
    sb.push_back(11'h010);
    sb.push_back(11'h011);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h010) begin n_fail++; $display("FAIL stall_release: push=%b lit=%h required 1111 010", ucq_push, uca2ucq); end
    step();
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h011) begin n_fail++; $display("FAIL stall_second: push=%b lit=%h required 1111 011", ucq_push, uca2ucq); end
    step();
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL stall_after: push=%b required 0000", ucq_push); end
    step();
  endtask

  task automatic test_clear();
    sb.push_back(11'h015);
    offer(0, 11'h015);
    offer(1, 11'h415);
    step();
    src_lit[2] = 11'h017;
    src_lit[3] = 11'h018;
    src_valid  = 4'b1100;
    step();
    src_valid = '0;
    clear     = 1'b1;
    @(negedge clk);
    n_tests++; if (src_ready !== 4'b0000) begin n_fail++; $display("FAIL clear_ready_low: got %b required 0000", src_ready); end
    n_tests++; if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL clear_no_push: push=%b required 0000", ucq_push); end
    step();
    clear = 1'b0;
    @(negedge clk);
    n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL clear_conflict: got %b required 0", conflict); end
    n_tests++; if (src_ready !== 4'b1111) begin n_fail++; $display("FAIL clear_pend: ready=%b required 1111", src_ready); end
    step();
    sb.push_back(11'h407);
    offer(0, 11'h407);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h407) begin n_fail++; $display("FAIL clear_repush: push=%b lit=%h required 1111 407", ucq_push, uca2ucq); end
    step();
  endtask

  task automatic test_async_reset();
    ucq_full   = 4'b1111;
    src_lit[0] = 11'h030;
    src_lit[1] = 11'h031;
    src_valid  = 4'b0011;
    step();
    src_valid = '0;
    step();
    @(negedge clk);
    n_tests++; if (src_ready[1:0] !== 2'b00) begin n_fail++; $display("FAIL arst_stalled: ready=%b required xx00", src_ready); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (src_ready !== 4'b1111) begin n_fail++; $display("FAIL arst_ready: got %b required 1111", src_ready); end
    n_tests++; if (ucq_push !== 4'b0000 || uca2ucq !== 11'h000 || conflict !== 1'b0) begin n_fail++; $display("FAIL arst_outputs: push=%b lit=%h conflict=%b required 0000 000 0", ucq_push, uca2ucq, conflict); end
    step();
    rst      = 1'b0;
    ucq_full = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (ucq_push !== 4'b0000) begin n_fail++; $display("FAIL arst_spurious: cycle %0d push=%b required 0000", c, ucq_push); end
      step();
    end
    // var 7 was assigned negated before reset; the positive literal must now push.
    sb.push_back(11'h007);
    offer(0, 11'h007);
    @(negedge clk);
    n_tests++; if (ucq_push !== 4'b1111 || uca2ucq !== 11'h007) begin n_fail++; $display("FAIL arst_table: push=%b lit=%h required 1111 007", ucq_push, uca2ucq); end
    step();
    @(negedge clk);
    n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL arst_no_conflict: got %b required 0", conflict); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fairness();
    test_dup_conflict();
    test_backpressure();
    test_clear();
    test_async_reset();
    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected pushes never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
